// File: rtl/beat_sequencer_if.sv
// Beat sequencer control/status bundle.
//   master : player control side; drives play_toggle, restart, mode, speed,
//            loop_en and loop_width, and observes the beat outputs.
//   slave  : beat_sequencer; drives ibeat, playing, beat_tick, wrap and dir.
// LEN is the song length in beats and sets the ibeat width.
interface beat_sequencer_if #(
  parameter int LEN = 64
);
  localparam int BW = $clog2(LEN);

  logic          play_toggle;
  logic          restart;
  logic [1:0]    mode;
  logic [1:0]    speed;
  logic          loop_en;
  logic [2:0]    loop_width;
  logic [BW-1:0] ibeat;
  logic          playing;
  logic          beat_tick;
  logic          wrap;
  logic          dir;

  modport master (
    output play_toggle, restart, mode, speed, loop_en, loop_width,
    input  ibeat, playing, beat_tick, wrap, dir
  );

  modport slave (
    input  play_toggle, restart, mode, speed, loop_en, loop_width,
    output ibeat, playing, beat_tick, wrap, dir
  );
endinterface

// File: rtl/beat_sequencer.sv
// beat_sequencer: beat-index generator for the music player.
// Runs on clk with an internal speed-scaled tick generator and produces ibeat
// with play/pause/stop, forward/reverse/ping-pong traversal and an aligned
// power-of-two loop region.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - beat_sequencer_if.slave:
//          play_toggle (pulse), restart (pulse), mode[1:0], speed[1:0],
//          loop_en, loop_width[2:0] in; ibeat[BW-1:0], playing, beat_tick,
//          wrap, dir out.
// Parameters: LEN (power of two, >= 64), CLK_HZ, BASE_BPS.
// Optional feature: define SEQ_SWING_EN to give even beats 3/2 and odd beats
// 1/2 of the nominal beat length (pair duration unchanged).
module beat_sequencer #(
  parameter int LEN      = 64,
  parameter int CLK_HZ   = 100_000_000,
  parameter int BASE_BPS = 8
) (
  input  logic              clk,
  input  logic              rst,
  beat_sequencer_if.slave   bus
);
  localparam int BW       = $clog2(LEN);
  localparam int TICK_DIV = CLK_HZ / BASE_BPS;
  // Large enough for the longest (swung, half-speed) beat.
  localparam int CW       = $clog2(3 * TICK_DIV + 1);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_PLAY,
    ST_PAUSE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] term;
  logic [31:0]   beat_len;
  logic [BW-1:0] ibeat;
  logic          dir;
  logic          beat_tick;
  logic          wrap;
  logic [BW-1:0] loop_start;
  logic          loop_en_q;
  logic [2:0]    loop_width_q;

  logic [2:0]    w;
  logic [BW-1:0] span;
  logic          reload;
  logic [BW-1:0] loop_start_eff;
  logic [BW-1:0] lo, hi;
  logic [BW-1:0] nx_ibeat;
  logic          nx_dir;
  logic          nx_wrap;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_STOP;
    else     state <= state_nx;
  end

  // Restart has priority; a simultaneous toggle is dropped.
  always_comb begin
    state_nx = state;
    if (bus.restart) begin
      state_nx = ST_STOP;
    end else if (bus.play_toggle) begin
      case (state)
        ST_STOP:  state_nx = ST_PLAY;
        ST_PLAY:  state_nx = ST_PAUSE;
        ST_PAUSE: state_nx = ST_PLAY;
        default:  state_nx = ST_STOP;
      endcase
    end
  end

  // Terminal count for the beat currently shown.
  always_comb begin
    case (bus.speed)
      2'd0:    beat_len = 32'(2 * TICK_DIV);
      2'd1:    beat_len = 32'(TICK_DIV);
      2'd2:    beat_len = 32'(TICK_DIV / 2);
      default: beat_len = 32'(TICK_DIV / 4);
    endcase
`ifdef SEQ_SWING_EN
    beat_len = ibeat[0] ? (beat_len >> 1) : ((beat_len * 32'd3) >> 1);
`endif
    term = CW'(beat_len - 32'd1);
  end

  // Loop region: width clamped to 2..6, start aligned down from ibeat.
  always_comb begin
    if (bus.loop_width < 3'd2)      w = 3'd2;
    else if (bus.loop_width > 3'd6) w = 3'd6;
    else                            w = bus.loop_width;
  end

  assign span   = ~({BW{1'b1}} << w);
  assign reload = bus.loop_en && (!loop_en_q || (bus.loop_width != loop_width_q));
  // The step taken in a reload cycle already sees the new region.
  assign loop_start_eff = reload ? (ibeat & ~span) : loop_start;
  // Aligned start, so OR-ing in span equals start + 2**w - 1.
  assign lo = bus.loop_en ? loop_start_eff          : '0;
  assign hi = bus.loop_en ? (loop_start_eff | span) : '1;

  // Next position for a step.
  always_comb begin
    nx_ibeat = ibeat;
    nx_dir   = dir;
    nx_wrap  = 1'b0;
    if ((ibeat < lo) || (ibeat > hi)) begin
      nx_wrap = 1'b1;
      if (bus.mode == 2'b01) begin
        nx_ibeat = hi;
        nx_dir   = 1'b1;
      end else begin
        nx_ibeat = lo;
        nx_dir   = 1'b0;
      end
    end else begin
      case (bus.mode)
        2'b01: begin
          nx_dir = 1'b1;
          if (ibeat == lo) begin
            nx_ibeat = hi;
            nx_wrap  = 1'b1;
          end else begin
            nx_ibeat = ibeat - 1'b1;
          end
        end
        2'b10: begin
          if (!dir) begin
            if (ibeat == hi) begin
              nx_ibeat = hi - 1'b1;
              nx_dir   = 1'b1;
              nx_wrap  = 1'b1;
            end else begin
              nx_ibeat = ibeat + 1'b1;
            end
          end else begin
            if (ibeat == lo) begin
              nx_ibeat = lo + 1'b1;
              nx_dir   = 1'b0;
              nx_wrap  = 1'b1;
            end else begin
              nx_ibeat = ibeat - 1'b1;
            end
          end
        end
        default: begin
          nx_dir = 1'b0;
          if (ibeat == hi) begin
            nx_ibeat = lo;
            nx_wrap  = 1'b1;
          end else begin
            nx_ibeat = ibeat + 1'b1;
          end
        end
      endcase
    end
  end

  // Tick counter, position and loop bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      ibeat        <= '0;
      dir          <= 1'b0;
      beat_tick    <= 1'b0;
      wrap         <= 1'b0;
      loop_start   <= '0;
      loop_en_q    <= 1'b0;
      loop_width_q <= '0;
    end else begin
      beat_tick    <= 1'b0;
      wrap         <= 1'b0;
      loop_en_q    <= bus.loop_en;
      loop_width_q <= bus.loop_width;
      if (reload) loop_start <= ibeat & ~span;

      if (bus.restart) begin
        cnt   <= '0;
        ibeat <= (bus.mode == 2'b01) ? '1 : '0;
      end else begin
        case (state)
          ST_PLAY: begin
            // >= so that a speed raise mid-beat steps immediately
            if (cnt >= term) begin
              cnt       <= '0;
              ibeat     <= nx_ibeat;
              dir       <= nx_dir;
              wrap      <= nx_wrap;
              beat_tick <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_PAUSE: cnt <= cnt;
          default:  cnt <= '0;
        endcase
      end
    end
  end

  assign bus.ibeat     = ibeat;
  assign bus.playing   = (state == ST_PLAY);
  assign bus.beat_tick = beat_tick;
  assign bus.wrap      = wrap;
  assign bus.dir       = dir;
endmodule
